// File: rtl/bpi_flash_pkg.sv
// Shared types and helpers for the BPI flash write engine: FSM state encoding,
// host/flash width ratio and alignment masks.
package bpi_flash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ERASE_REQ,
        ST_ERASE_WAIT,
        ST_WAIT_DATA,
        ST_PROG_REQ,
        ST_PROG_DATA,
        ST_PROG_WAIT,
        ST_DONE
    } wr_state_e;

    localparam int DEF_BUF_WORDS = 512;
    localparam int DEF_BLK_WORDS = 65536;

    function automatic int calc_ratio(input int host_wd, input int flash_wd);
        return host_wd / flash_wd;
    endfunction

    // Low-bit mask that must be clear for a value aligned to 'bytes'.
    function automatic logic [31:0] align_mask(input int unsigned bytes);
        return 32'(bytes - 1);
    endfunction

endpackage

// File: rtl/bpi_flash_wr_engine_if.sv
// Handshake between the write engine (master) and bpi_flash_drive (slave):
// block erase request and buffer-program request with per-word data strobe.
interface bpi_flash_wr_engine_if #(
    parameter int FLASH_ADDR_WD = 26,
    parameter int FLASH_DATA_WD = 16
);
    logic                     flash_busy;
    logic                     erase_en;
    logic [FLASH_ADDR_WD-1:0] block_num;
    logic                     buff_wr_en;
    logic [FLASH_ADDR_WD-1:0] buff_wr_addr;
    logic [9:0]               buff_wr_len;
    logic                     buff_wr_vld;
    logic [FLASH_DATA_WD-1:0] buff_wr_din;

    modport master (
        input  flash_busy, buff_wr_vld,
        output erase_en, block_num, buff_wr_en, buff_wr_addr, buff_wr_len, buff_wr_din
    );

    modport slave (
        output flash_busy, buff_wr_vld,
        input  erase_en, block_num, buff_wr_en, buff_wr_addr, buff_wr_len, buff_wr_din
    );
endinterface

// File: rtl/bpi_flash_sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and soft clear.
// dout reads as zero while empty so downstream data never shows stale words.
module bpi_flash_sfifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push, pop;

    assign full  = (cnt_q == FULL_CNT);
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;
    assign push  = wr && !full;
    assign pop   = rd && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/bpi_flash_wr_engine.sv
// BPI flash write engine: splits a byte-addressed host job into program-buffer
// aligned chunks, optionally erasing each touched block, feeding bpi_flash_drive.
module bpi_flash_wr_engine
    import bpi_flash_pkg::*;
#(
    parameter int FIFO_DATA_WD  = 32,
    parameter int FLASH_ADDR_WD = 26,
    parameter int FLASH_DATA_WD = 16,
    parameter int BUF_WORDS     = DEF_BUF_WORDS,
    parameter int BLK_WORDS     = DEF_BLK_WORDS,
    parameter int FIFO_DEPTH    = 1024
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic                           cfg_rst,
    input  logic                           cfg_wr_trig,
    input  logic [31:0]                    cfg_wr_len,
    input  logic [31:0]                    cfg_wr_addr,
    input  logic                           cfg_auto_erase,
    output logic                           sts_wr_cpl,
    output logic                           sts_wr_err,
    input  logic                           fifo_wr,
    input  logic [FIFO_DATA_WD-1:0]        fifo_din,
    output logic                           fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_wr_cnt,
    bpi_flash_wr_engine_if.master          flash
);
    localparam int RATIO  = calc_ratio(FIFO_DATA_WD, FLASH_DATA_WD);
    localparam int BYTES  = FIFO_DATA_WD / 8;
    localparam int BUF_AW = $clog2(BUF_WORDS);
    localparam int BLK_AW = $clog2(BLK_WORDS);
    localparam logic [1:0]               HALF_LAST = 2'(RATIO - 1);
    localparam logic [FLASH_ADDR_WD-1:0] BLK_MASK  = ~FLASH_ADDR_WD'(BLK_WORDS - 1);
    localparam logic [32:0]              JOB_LIMIT = 33'd1 << FLASH_ADDR_WD;

    wr_state_e                state_q, state_d;
    logic [FLASH_ADDR_WD-1:0] wa_q, wa_d;
    logic [30:0]              rem_q, rem_d;
    logic [10:0]              vld_cnt_q, vld_cnt_d;
    logic                     auto_q, auto_d;
    logic                     first_q, first_d;
    logic                     bad_q, bad_d;
    logic                     busy_seen_q, busy_seen_d;
    logic [1:0]               half_q, half_d;
    logic                     cpl_q, cpl_d, err_q, err_d;
    logic                     erase_en_q, erase_en_d, buff_wr_en_q, buff_wr_en_d;
    logic [FLASH_ADDR_WD-1:0] block_num_q, block_num_d, addr_q, addr_d;
    logic [9:0]               len_q, len_d;

    logic                     fifo_rd, fifo_empty;
    logic [FIFO_DATA_WD-1:0]  fifo_dout;
    logic [10:0]              room, chunk;
    logic [15:0]              avail;
    logic [32:0]              job_end;
    logic [FLASH_ADDR_WD-1:0] next_wa;
    logic                     need_erase, need_erase_next, vld_take;

    bpi_flash_sfifo #(
        .WIDTH (FIFO_DATA_WD),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (cfg_rst),
        .wr    (fifo_wr),
        .din   (fifo_din),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .cnt   (fifo_wr_cnt)
    );

    // Current flash word is the selected slice of the FIFO head, LSB half first.
    assign flash.buff_wr_din  = fifo_dout[32'(half_q) * FLASH_DATA_WD +: FLASH_DATA_WD];
    assign flash.erase_en     = erase_en_q;
    assign flash.block_num    = block_num_q;
    assign flash.buff_wr_en   = buff_wr_en_q;
    assign flash.buff_wr_addr = addr_q;
    assign flash.buff_wr_len  = len_q;
    assign sts_wr_cpl         = cpl_q;
    assign sts_wr_err         = err_q;

    always_comb begin
        room            = 11'(BUF_WORDS) - 11'(wa_q[BUF_AW-1:0]);
        chunk           = (rem_q < 31'(room)) ? rem_q[10:0] : room;
        avail           = 16'(fifo_wr_cnt) * 16'(RATIO) - 16'(half_q);
        job_end         = 33'(wa_q) + 33'(rem_q);
        next_wa         = wa_q + FLASH_ADDR_WD'(chunk);
        need_erase      = auto_q && (first_q || wa_q[BLK_AW-1:0] == '0);
        need_erase_next = auto_q && (next_wa[BLK_AW-1:0] == '0);
        vld_take        = (state_q == ST_PROG_DATA) && flash.buff_wr_vld;
        fifo_rd         = vld_take && (half_q == HALF_LAST) && !fifo_empty;
    end

    always_comb begin
        state_d      = state_q;
        wa_d         = wa_q;
        rem_d        = rem_q;
        vld_cnt_d    = vld_cnt_q;
        auto_d       = auto_q;
        first_d      = first_q;
        bad_d        = bad_q;
        busy_seen_d  = busy_seen_q;
        half_d       = half_q;
        cpl_d        = 1'b0;
        err_d        = 1'b0;
        erase_en_d   = 1'b0;
        buff_wr_en_d = 1'b0;
        block_num_d  = block_num_q;
        addr_d       = addr_q;
        len_d        = len_q;

        if (vld_take) begin
            half_d = (half_q == HALF_LAST) ? 2'd0 : half_q + 2'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_wr_trig) begin
                    wa_d    = cfg_wr_addr[FLASH_ADDR_WD:1];
                    rem_d   = cfg_wr_len[31:1];
                    auto_d  = cfg_auto_erase;
                    first_d = 1'b1;
                    bad_d   = (cfg_wr_len == '0)
                           || ((cfg_wr_len  & align_mask(BYTES)) != '0)
                           || ((cfg_wr_addr & align_mask(BYTES)) != '0);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (bad_q || job_end > JOB_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = need_erase ? ST_ERASE_REQ : ST_WAIT_DATA;
                end
            end
            ST_ERASE_REQ: begin
                if (!flash.flash_busy) begin
                    erase_en_d  = 1'b1;
                    block_num_d = wa_q & BLK_MASK;
                    busy_seen_d = 1'b0;
                    state_d     = ST_ERASE_WAIT;
                end
            end
            ST_ERASE_WAIT: begin
                if (busy_seen_q && !flash.flash_busy) begin
                    state_d = ST_WAIT_DATA;
                end
                busy_seen_d = busy_seen_q | flash.flash_busy;
            end
            ST_WAIT_DATA: begin
                // Whole chunk must already be buffered so the drive never starves.
                if (avail >= 16'(chunk)) begin
                    state_d = ST_PROG_REQ;
                end
            end
            ST_PROG_REQ: begin
                if (!flash.flash_busy) begin
                    buff_wr_en_d = 1'b1;
                    addr_d       = wa_q;
                    len_d        = 10'(chunk - 11'd1);
                    vld_cnt_d    = '0;
                    state_d      = ST_PROG_DATA;
                end
            end
            ST_PROG_DATA: begin
                if (vld_take) begin
                    vld_cnt_d = vld_cnt_q + 11'd1;
                    if (vld_cnt_q + 11'd1 == chunk) begin
                        busy_seen_d = 1'b0;
                        state_d     = ST_PROG_WAIT;
                    end
                end
            end
            ST_PROG_WAIT: begin
                if (busy_seen_q && !flash.flash_busy) begin
                    wa_d    = next_wa;
                    rem_d   = rem_q - 31'(chunk);
                    first_d = 1'b0;
                    if (rem_q == 31'(chunk)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = need_erase_next ? ST_ERASE_REQ : ST_WAIT_DATA;
                    end
                end
                busy_seen_d = busy_seen_q | flash.flash_busy;
            end
            ST_DONE: begin
                cpl_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || cfg_rst) begin
            state_q      <= ST_IDLE;
            auto_q       <= 1'b0;
            first_q      <= 1'b0;
            bad_q        <= 1'b0;
            busy_seen_q  <= 1'b0;
            half_q       <= 2'd0;
            cpl_q        <= 1'b0;
            err_q        <= 1'b0;
            erase_en_q   <= 1'b0;
            buff_wr_en_q <= 1'b0;
            block_num_q  <= '0;
            addr_q       <= '0;
            len_q        <= '0;
        end else begin
            state_q      <= state_d;
            auto_q       <= auto_d;
            first_q      <= first_d;
            bad_q        <= bad_d;
            busy_seen_q  <= busy_seen_d;
            half_q       <= half_d;
            cpl_q        <= cpl_d;
            err_q        <= err_d;
            erase_en_q   <= erase_en_d;
            buff_wr_en_q <= buff_wr_en_d;
            block_num_q  <= block_num_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
        end
    end

    // Job address/length and word counter are always loaded before use.
    always_ff @(posedge sys_clk) begin
        wa_q      <= wa_d;
        rem_q     <= rem_d;
        vld_cnt_q <= vld_cnt_d;
    end

endmodule
